// File: rtl/sub8_serial.sv
// Bit-serial subtractor: DIFF = A - B with borrow-out, one bit per clock, LSB first.
// One full-subtractor cell is reused for every bit position. A start/busy/done handshake sequences each operation.

module sub8_serial_fs (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module sub8_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, d_sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d_bit, br_nxt;
    logic             last;
    logic             load;

    sub8_serial_fs u_fs (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (br),
        .d  (d_bit),
        .bo (br_nxt)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == SHIFT);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Result registers only move on the final bit, so they hold across SHIFT and new starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            cnt  <= '0;
            br   <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                a_sr <= a;
                b_sr <= b;
                br   <= 1'b0;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                d_sr <= {d_bit, d_sr[WIDTH-1:1]};
                br   <= br_nxt;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    diff <= {d_bit, d_sr[WIDTH-1:1]};
                    bout <= br_nxt;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sub8_serial.sv
// Scoreboard bench for sub8_serial: stimulus pushes expected results, a monitor pops on DONE.
// The reference model is plain unsigned arithmetic on WIDTH+1 bits.

module tb_sub8_serial;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             busy, done, bout;
    logic [WIDTH-1:0] diff;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        int               scyc;
    } exp_t;

    exp_t             sb[$];
    int               total = 0, bad = 0;
    int               cyc = 0;
    int               n_acc = 0, n_done = 0;
    logic [WIDTH-1:0] last_diff = '0;
    logic             last_bout = 1'b0;

    sub8_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("diff", 32'(diff), 32'(e.diff));
                chk("bout", 32'(bout), 32'(e.bout));
                chk("latency", 32'(cyc - e.scyc), 32'(WIDTH));
                last_diff = e.diff;
                last_bout = e.bout;
            end
        end
    end

    // Caller is at a negedge with the DUT idle; start is sampled at the next posedge.
    task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        exp_t             e;
        logic [WIDTH:0]   r;
        r      = {1'b0, va} - {1'b0, vb};
        e.diff = r[WIDTH-1:0];
        e.bout = r[WIDTH];
        e.scyc = cyc + 1;
        sb.push_back(e);
        n_acc++;
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
    endtask

    // Returns at the negedge where DONE is seen; optionally fires ignored starts mid-op.
    task automatic wait_done(input int spur_pct);
        bit seen = 0;
        for (int i = 0; i < 4 * WIDTH && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1;
                chk("busy_at_done", 32'(busy), 32'd0);
            end else begin
                chk("busy_in_op", 32'(busy), 32'd1);
                chk("diff_hold", 32'(diff), 32'(last_diff));
                chk("bout_hold", 32'(bout), 32'(last_bout));
                if (spur_pct > 0 && $urandom_range(99) < spur_pct) begin
                    start = 1'b1;
                    a     = WIDTH'($urandom);
                    b     = WIDTH'($urandom);
                end
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", 4 * WIDTH);
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("no_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);

        // Directed cases, including back-to-back starts in the DONE cycle.
        issue(8'h33, 8'hAA); wait_done(0);
        @(negedge clk);
        issue(8'hE3, 8'h55); wait_done(0);
        issue(8'h0F, 8'h55); wait_done(0);
        @(negedge clk);
        issue(8'hCC, 8'hAA); wait_done(0);
        issue(8'h55, 8'h55); wait_done(0);
        issue(8'h00, 8'h01); wait_done(0);
        @(negedge clk);

        // Start while busy must be ignored.
        issue(8'hCC, 8'hAA);
        repeat (2) @(negedge clk);
        a = 8'h00; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0);
        quiet(12);

        // Reset mid-operation aborts without a DONE.
        issue(8'h12, 8'h34);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        n_acc--;
        last_diff = '0;
        last_bout = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        quiet(20);

        // Random sweep with random gaps and spurious mid-op starts.
        for (int k = 0; k < 1000; k++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom));
            wait_done(10);
            if ($urandom_range(2) != 0) begin
                for (int g = $urandom_range(1, 2); g > 0; g--) @(negedge clk);
            end
        end
        quiet(3);

        chk("done_count", 32'(n_done), 32'(n_acc));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
